edge_evt_packer: RTL and testbench

- Downstream consumer of the single-cycle edge pulses produced by the edge-detector stage.
- Timestamps each detected edge with the number of ce-qualified cycles since the previous edge, plus a wrapping sequence number.
- Packs each event into one record and pushes it into the host-bound write FIFO through a wr_en/full handshake.
- A one-record holding register absorbs short FIFO back-pressure; edges that cannot be stored are dropped, and the gap shows in the sequence number.

---
 rtl/edge_evt_packer.sv | 95 +++++++++
 tb/tb_edge_evt_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/edge_evt_packer.sv
// Edge event packer: timestamps edge pulses with a saturating inter-edge delta and a
// wrapping sequence number, then pushes {seq, delta} records into a write FIFO.
// Define EDGE_EVT_PACKER_DROP_CNT_EN to add the saturating drop_cnt output.
module edge_evt_packer #(
  parameter  int CNT_W  = 24,
  parameter  int SEQ_W  = 8,
  localparam int DATA_W = SEQ_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              edge_in,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_din,
`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic              pend
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [SEQ_W-1:0]   seq;
  logic               evt;
  logic               load;
  logic               drop;

  assign evt        = ce & edge_in;
  assign pend       = (state == FULL);
  assign fifo_wr_en = pend & ~fifo_full;
  // Saturating increment; also serves as the captured delta on an edge.
  assign cnt_inc    = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (evt) begin
          load      = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (evt) begin
          if (fifo_full) drop = 1'b1;
          else           load = 1'b1;
        end else if (!fifo_full) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      cnt      <= '0;
      seq      <= '0;
      fifo_din <= '0;
    end else begin
      state <= state_nxt;
      if (ce) begin
        cnt <= edge_in ? '0 : cnt_inc;
      end
      if (evt) begin
        seq <= seq + SEQ_W'(1);
      end
      if (load) begin
        fifo_din <= {seq, cnt_inc};
      end
    end
  end

`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_edge_evt_packer.sv
// Self-checking bench for edge_evt_packer: a cycle model pushes expected records into a
// queue as edges are driven; each observed FIFO write pops and compares one entry.
module tb_edge_evt_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, edge_in, fifo_full;
  logic        fifo_wr_en, pend;
  logic [31:0] fifo_din;
`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  logic        ce4, edge4, full4;
  logic        wr_en4, pend4;
  logic [11:0] din4;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wr_log[$];
  logic [23:0] m_cnt;
  logic [7:0]  m_seq;
  logic        m_pend;
  logic [15:0] m_drops;

  always #5 clk = ~clk;

  edge_evt_packer u_dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .edge_in    (edge_in),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .pend       (pend)
  );

  edge_evt_packer #(.CNT_W(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce4),
    .edge_in    (edge4),
    .fifo_full  (full4),
    .fifo_wr_en (wr_en4),
    .fifo_din   (din4),
`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
    .drop_cnt   (),
`endif
    .pend       (pend4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt   = '0;
    m_seq   = '0;
    m_pend  = 1'b0;
    m_drops = '0;
    exp_q.delete();
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic cyc(input logic c, input logic e, input logic f);
    logic        acc;
    logic [23:0] delta;
    ce = c; edge_in = e; fifo_full = f;
    @(negedge clk);
    acc = m_pend & ~f;
    check("pend", pend, m_pend);
    check("wr_en", fifo_wr_en, acc);
`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
    check("drop_cnt", drop_cnt, m_drops);
`endif
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1'b1, 1'b0);
      end else begin
        check("record", fifo_din, exp_q.pop_front());
      end
      wr_log.push_back(fifo_din);
    end
    @(posedge clk);
    delta = (m_cnt == 24'hFFFFFF) ? m_cnt : m_cnt + 24'd1;
    if (c) m_cnt = e ? 24'd0 : delta;
    if (c && e) begin
      if (!m_pend || acc) begin
        exp_q.push_back({m_seq, delta});
        m_pend = 1'b1;
      end else if (m_drops != 16'hFFFF) begin
        m_drops = m_drops + 16'd1;
      end
      m_seq = m_seq + 8'd1;
    end else if (acc) begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  initial begin
    int first_idx;
    rst = 1'b1; ce = 1'b0; edge_in = 1'b0; fifo_full = 1'b0;
    ce4 = 1'b0; edge4 = 1'b0; full4 = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_pend", pend, 1'b0);
    check("rst_wr_en", fifo_wr_en, 1'b0);
    check("rst_din", fifo_din, 32'd0);
    rst = 1'b0;

    // Edges sampled at the 6th and 10th edges after reset.
    repeat (5) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 0);
    repeat (2) cyc(1, 0, 0);
    check("t1_writes", wr_log.size(), 2);
    check("t1_rec0", wr_log[0], {8'd0, 24'd6});
    check("t1_rec1", wr_log[1], {8'd1, 24'd4});

    // Four back-to-back edges: one write per cycle, delta 1.
    repeat (4) cyc(1, 1, 0);
    cyc(1, 0, 0);
    check("t2_last", wr_log[wr_log.size()-1], {8'd5, 24'd1});

    // FIFO full across three edges: first held, next two dropped.
    repeat (3) cyc(1, 1, 1);
    check("t3_pend", pend, 1'b1);
    first_idx = wr_log.size();
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    check("t3_writes", wr_log.size() - first_idx, 2);
    check("t3_seq_gap", wr_log[first_idx+1][31:24] - wr_log[first_idx][31:24], 8'd3);
`ifdef EDGE_EVT_PACKER_DROP_CNT_EN
    check("t3_drop_cnt", drop_cnt, 16'd2);
`endif

    // ce toggling with edge_in held high: drain happens in ce=0 cycles.
    repeat (6) begin
      cyc(1, 1, 0);
      cyc(0, 1, 0);
    end
    cyc(0, 0, 0);
    check("t4_last", wr_log[wr_log.size()-1][23:0], 24'd1);

    // Long back-to-back run so seq wraps past 255.
    repeat (260) cyc(1, 1, 0);
    cyc(0, 0, 0);

    // Narrow counter saturates at 4'hF after 20 idle cycles.
    ce4 = 1'b1;
    repeat (20) cyc(0, 0, 0);
    edge4 = 1'b1;
    cyc(0, 0, 0);
    ce4 = 1'b0; edge4 = 1'b0;
    check("t5_pend4", pend4, 1'b1);
    check("t5_din4", din4, {8'd0, 4'hF});
    check("t5_wr_en4", wr_en4, 1'b0);

    // Asynchronous reset while a record is held against a full FIFO.
    cyc(1, 1, 1);
    check("t6_pend_before", pend, 1'b1);
    #2 rst = 1'b1;
    fifo_full = 1'b0;
    #1;
    check("t6_pend_async", pend, 1'b0);
    check("t6_wr_en_async", fifo_wr_en, 1'b0);
    check("t6_din_async", fifo_din, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    first_idx = wr_log.size();
    repeat (2) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    check("t6_writes", wr_log.size() - first_idx, 1);
    check("t6_rec", wr_log[first_idx], {8'd0, 24'd3});
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
